// File: rtl/echo_cancel_if.sv
// Sample-stream bundle for echo_cancel: input samples with their per-sample
// gain/delay controls, and the cleaned output stream with its status flags.
interface echo_cancel_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 12
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] audio_in;
    logic [5:0]                   gain;
    logic [ADDR_W-1:0]            delay_num;
    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] clean_data;
    logic                         sat_flag;
    logic                         primed;

    modport master (
        output in_valid, audio_in, gain, delay_num,
        input  out_valid, clean_data, sat_flag, primed
    );

    modport slave (
        input  in_valid, audio_in, gain, delay_num,
        output out_valid, clean_data, sat_flag, primed
    );
endinterface

// File: rtl/echo_cancel.sv
// Feedback echo canceller: clean[n] = audio[n] - floor(g * clean[n-D]), two-cycle latency.
// Define ECHO_CANCEL_SAT_EN to saturate results and drive sat_flag; otherwise results wrap.
module echo_cancel #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 12
) (
    input  logic         clk,
    input  logic         reset,
    echo_cancel_if.slave io
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = DATA_WIDTH + 7;
    localparam logic [ADDR_W-1:0] D_MIN = ADDR_W'(4);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] dlat_q, dlat_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic              primed_q, primed_d;
    logic              vld_p0_q, vld_p0_d;
    logic              vld_p1_q, vld_p1_d;
    logic signed [DATA_WIDTH-1:0] clean_q, clean_d;
    logic              sat_q, sat_d;

    logic [ADDR_W-1:0] d_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              echo_en_d;

    logic signed [DATA_WIDTH-1:0] audio_p0_q, audio_p0_d;
    logic signed [DATA_WIDTH-1:0] echo_p0_q, echo_p0_d;
    logic [5:0]                   gain_p0_q, gain_p0_d;
    logic                         echo_en_p0_q, echo_en_p0_d;
    logic [ADDR_W-1:0]            wp_p0_q, wp_p0_d;
    logic [ADDR_W-1:0]            wp_p1_q, wp_p1_d;

    logic signed [DATA_WIDTH-1:0] echo_term;
    logic signed [PW-1:0]         echo_x, gain_x, prod;
    logic signed [DATA_WIDTH:0]   diff;
    logic signed [DATA_WIDTH-1:0] result;
    logic                         ovf;
    logic                         unused_bits;

    logic signed [DATA_WIDTH-1:0] buf_mem [DEPTH];

    function automatic logic ovf_chk(input logic signed [DATA_WIDTH:0] v);
        return v[DATA_WIDTH] != v[DATA_WIDTH-1];
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat_val(input logic signed [DATA_WIDTH:0] v);
        if (ovf_chk(v))
            return v[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return v[DATA_WIDTH-1:0];
    endfunction

    // Acceptance: mode control, delay latch and echo read address.
    always_comb begin
        d_req     = (io.delay_num < D_MIN) ? D_MIN : io.delay_num;
        rd_addr   = wp_q - d_req;
        state_d   = state_q;
        dlat_d    = dlat_q;
        fill_d    = fill_q;
        wp_d      = wp_q;
        echo_en_d = 1'b0;
        if (io.in_valid) begin
            wp_d   = wp_q + ADDR_W'(1);
            dlat_d = d_req;
            // A new delay or a cold start must refill D fresh words before the echo is trusted.
            if (d_req != dlat_q || state_q == IDLE) begin
                state_d = PRIME;
                fill_d  = ADDR_W'(1);
            end else if (state_q == PRIME) begin
                if (fill_q == dlat_q) begin
                    state_d   = RUN;
                    echo_en_d = 1'b1;
                end else begin
                    fill_d = fill_q + ADDR_W'(1);
                end
            end else begin
                echo_en_d = 1'b1;
            end
        end
        primed_d     = (state_d == RUN);
        vld_p0_d     = io.in_valid;
        audio_p0_d   = io.audio_in;
        gain_p0_d    = io.gain;
        echo_p0_d    = buf_mem[rd_addr];
        echo_en_p0_d = echo_en_d;
        wp_p0_d      = wp_q;
    end

    // Stage p0 -> p1: scale the echo, subtract, range-handle.
    always_comb begin
        echo_term = echo_en_p0_q ? echo_p0_q : '0;
        echo_x    = {{7{echo_term[DATA_WIDTH-1]}}, echo_term};
        gain_x    = {{DATA_WIDTH{1'b0}}, gain_p0_q};
        prod      = echo_x * gain_x;
        diff      = {audio_p0_q[DATA_WIDTH-1], audio_p0_q} - prod[PW-1:6];
`ifdef ECHO_CANCEL_SAT_EN
        result    = sat_val(diff);
        ovf       = ovf_chk(diff);
`else
        result    = diff[DATA_WIDTH-1:0];
        ovf       = 1'b0;
`endif
        vld_p1_d  = vld_p0_q;
        wp_p1_d   = wp_p0_q;
        clean_d   = vld_p0_q ? result : clean_q;
        sat_d     = vld_p0_q & ovf;
    end

    assign unused_bits = ^{prod[5:0], diff[DATA_WIDTH]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            dlat_q   <= D_MIN;
            fill_q   <= '0;
            wp_q     <= '0;
            primed_q <= 1'b0;
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            clean_q  <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dlat_q   <= dlat_d;
            fill_q   <= fill_d;
            wp_q     <= wp_d;
            primed_q <= primed_d;
            vld_p0_q <= vld_p0_d;
            vld_p1_q <= vld_p1_d;
            clean_q  <= clean_d;
            sat_q    <= sat_d;
        end
    end

    always_ff @(posedge clk) begin
        audio_p0_q   <= audio_p0_d;
        gain_p0_q    <= gain_p0_d;
        echo_p0_q    <= echo_p0_d;
        echo_en_p0_q <= echo_en_p0_d;
        wp_p0_q      <= wp_p0_d;
        wp_p1_q      <= wp_p1_d;
    end

    // Stage p1: the emitted sample becomes history at the slot it was accepted into.
    always_ff @(posedge clk) begin
        if (vld_p1_q) buf_mem[wp_p1_q] <= clean_q;
    end

    assign io.out_valid  = vld_p1_q;
    assign io.clean_data = clean_q;
    assign io.sat_flag   = sat_q;
    assign io.primed     = primed_q;
endmodule

// File: tb/tb_echo_cancel.sv
// Scoreboard bench for echo_cancel: a sample-indexed reference model predicts each
// output at acceptance; outputs, hold behaviour, sat_flag and primed are checked per cycle.
module tb_echo_cancel;
    localparam int DW  = 16;
    localparam int AW  = 6;
    localparam int LIM = 1 << (DW - 1);

    logic clk = 1'b0;
    logic reset = 1'b1;

    echo_cancel_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) ifc ();
    echo_cancel #(.DATA_WIDTH(DW), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .io(ifc));

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int clean;
        int sat;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   m_mode = 0;
    int   m_fill = 0;
    int   m_d = 4;
    int   m_primed = 0;
    int   last_clean = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, act, exp);
        end
    endtask

    task automatic model_accept(input int a, input int g, input int dnum);
        int d, en, term, diff, res, sat;
        d  = (dnum < 4) ? 4 : dnum;
        en = 0;
        if (d != m_d || m_mode == 0) begin
            m_d = d; m_fill = 1; m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_fill == m_d) begin m_mode = 2; en = 1; end
            else m_fill++;
        end else begin
            en = 1;
        end
        term = en ? ((hist[hist.size() - m_d] * g) >>> 6) : 0;
        diff = a - term;
        sat  = 0;
`ifdef ECHO_CANCEL_SAT_EN
        if (diff > LIM - 1) begin res = LIM - 1; sat = 1; end
        else if (diff < -LIM) begin res = -LIM; sat = 1; end
        else res = diff;
`else
        res = diff & ((1 << DW) - 1);
        if (res >= LIM) res = res - 2 * LIM;
`endif
        hist.push_back(res);
        sb.push_back('{cyc + 1, res, sat});
        m_primed = (m_mode == 2) ? 1 : 0;
    endtask

    task automatic monitor();
        exp_t e;
        if (ifc.out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out", int'(ifc.out_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc, e.cyc);
                chk("clean", int'(ifc.clean_data), e.clean);
                chk("sat", int'(ifc.sat_flag), e.sat);
                last_clean = e.clean;
            end
        end else begin
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                chk("missing_out", int'(ifc.out_valid), 1);
                sb.delete(0);
            end
            chk("sat_idle", int'(ifc.sat_flag), 0);
            chk("hold", int'(ifc.clean_data), last_clean);
        end
        chk("primed", int'(ifc.primed), m_primed);
    endtask

    task automatic step(input logic iv, input int a, input int g, input int dnum);
        ifc.in_valid  = iv;
        ifc.audio_in  = a[DW-1:0];
        ifc.gain      = g[5:0];
        ifc.delay_num = dnum[AW-1:0];
        @(posedge clk);
        cyc++;
        if (iv && !reset) model_accept(a, g, dnum);
        #1;
        monitor();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifc.in_valid = 1'b0;
        sb.delete();
        hist.delete();
        m_mode = 0; m_fill = 0; m_d = 4; m_primed = 0; last_clean = 0;
        repeat (2) step(1'b0, 0, 0, 4);
        reset = 1'b0;
    endtask

    initial begin
        int dsel, g;
        ifc.in_valid = 1'b0; ifc.audio_in = '0; ifc.gain = '0; ifc.delay_num = AW'(4);
        do_reset();

        // Idle after reset: nothing emitted, outputs at zero.
        repeat (6) step(1'b0, 0, 0, 4);

        // Unity pass-through with gain 0.
        step(1'b1, 1000, 0, 4);
        repeat (7) step(1'b1, 0, 0, 4);
        repeat (3) step(1'b0, 0, 0, 4);

        // Half-gain echo fully cancelled; primed rises on the 5th sample.
        do_reset();
        step(1'b1, 1000, 32, 4);
        repeat (3) step(1'b1, 0, 32, 4);
        step(1'b1, 500, 32, 4);
        repeat (5) step(1'b1, 0, 32, 4);
        repeat (3) step(1'b0, 0, 0, 4);

        // Large gain driving the result out of range.
        do_reset();
        step(1'b1, 32767, 63, 4);
        repeat (3) step(1'b1, 0, 63, 4);
        step(1'b1, -32768, 63, 4);
        repeat (3) step(1'b0, 0, 0, 4);

        // Delay change 4 -> 8 while running.
        repeat (6) step(1'b1, $urandom_range(0, 4000) - 2000, 40, 4);
        repeat (20) step(1'b1, $urandom_range(0, 4000) - 2000, 40, 8);
        repeat (3) step(1'b0, 0, 0, 8);

        // Reset one cycle after an accepted sample discards it.
        step(1'b1, 1234, 10, 4);
        do_reset();
        step(1'b1, 777, 20, 4);
        repeat (6) step(1'b1, 100, 20, 4);
        repeat (3) step(1'b0, 0, 0, 4);

        // Random gaps, gains, full-range audio and occasional delay changes incl. clamped values.
        dsel = 5;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 3) dsel = $urandom_range(0, 9);
            g = $urandom_range(0, 63);
            step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 $urandom_range(0, 65535) - 32768, g, dsel);
        end

        // Maximum delay with pointer wrap-around.
        for (int i = 0; i < 160; i++)
            step(1'b1, $urandom_range(0, 8000) - 4000, 50, (1 << AW) - 1);

        repeat (4) step(1'b0, 0, 0, (1 << AW) - 1);
        chk("drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/echo_cancel.md
ECHO_CANCEL -- requirements
Module: echo_cancel

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width (signed two's complement).
REQ-002 SHALL have parameter ADDR_W, default 12, delay-line address width (depth 2^ADDR_W words).
REQ-003 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  audio_in valid this cycle; no backpressure.
- audio_in  input  DATA_WIDTH  echo-bearing sample, signed.
- gain  input  6  unsigned Q0.6 echo gain, g = gain/64.
- delay_num  input  ADDR_W  echo delay in samples.
- out_valid  output  1  clean_data valid, single-cycle pulse.
- clean_data  output  DATA_WIDTH  echo-removed sample, signed.
- sat_flag  output  1  pulses with out_valid when the result saturated.
- primed  output  1  high while state is RUN.

Function
REQ-004 SHALL compute clean[n] = audio_in[n] - floor(g * clean[n-D]) per accepted sample, where D is the latched delay (inverse of the echo path).
REQ-005 SHALL store every clean sample in a circular buffer of 2^ADDR_W words at write pointer wp; wp increments on each accepted sample and wraps from 2^ADDR_W-1 to 0.
REQ-006 SHALL read the echo term from address (wp - D) mod 2^ADDR_W.
REQ-007 SHALL clamp delay_num below 4 to 4; the effective D is 4..2^ADDR_W-1.
REQ-008 SHALL produce out_valid exactly 2 cycles after the accepting in_valid; back-to-back in_valid SHALL yield back-to-back out_valid.
REQ-009 SHALL write the clean sample to the buffer in the same cycle out_valid asserts, at the wp captured on acceptance.
REQ-010 SHALL form the product as signed (DATA_WIDTH+7)-bit, then arithmetic-shift right 6 (floor).
REQ-011 SHALL form the difference at DATA_WIDTH+1 bits before range handling.
REQ-012 SHALL implement states IDLE, PRIME, RUN:
- IDLE: after reset; first accepted sample -> PRIME.
- PRIME: echo term forced to 0; fill counter counts accepted samples; -> RUN when the fill counter reaches D.
- RUN: echo term applied.
REQ-013 SHALL, on an accepted sample whose delay_num (after clamping) differs from the latched D: latch the new D, clear the fill counter, and enter PRIME; the buffer contents are not cleared.
REQ-014 SHALL sample gain per accepted sample; gain=0 SHALL give clean_data = audio_in.
REQ-015 SHALL hold clean_data and sat_flag stable between out_valid pulses; sat_flag SHALL be 0 when out_valid is 0.

Reset
REQ-016 SHALL, while reset is high, force out_valid=0, clean_data=0, sat_flag=0, primed=0, wp=0, fill counter=0, D=4, state=IDLE, and discard in-flight pipeline samples.
REQ-017 SHALL not require buffer clearing at reset; PRIME guarantees stale words are never used.

Configuration
REQ-018 SHALL honour macro ECHO_CANCEL_SAT_EN:
- Defined: results outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] saturate to the nearest bound and sat_flag pulses.
- Undefined: result is the low DATA_WIDTH bits (wrap); sat_flag is tied 0.

Verification
REQ-019 Reset released, no input -> out_valid=0, clean_data=0, primed=0 indefinitely.
REQ-020 gain=0, delay_num=4, impulse 1000 then zeros -> clean_data 1000 two cycles after acceptance, then 0s.
REQ-021 gain=32, delay_num=4, inputs 1000,0,0,0,500,0... -> outputs 1000,0,0,0,0,0...; primed rises on the 5th sample.
REQ-022 SAT_EN defined, gain=63, delay_num=4, inputs 32767,0,0,0,-32768 -> 5th output -32768 with sat_flag=1 (unsaturated value -65023).
REQ-023 Reset asserted one cycle after in_valid -> no out_valid follows; state IDLE; next sample is treated as the first.
REQ-024 RUN with delay_num=4, delay_num changed to 8 -> primed falls on that sample; the echo term is 0 for 8 samples, then applied from clean[n-8].
